// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: free-running h/v counters with registered sync,
// data-enable, pixel coordinates and line/frame strobes, all mutually aligned.
module vga_sync_gen #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_ce,
  output logic       hs,
  output logic       vs,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // Compares run at 11 bits so a sync window ending exactly at 1024 still decodes.
  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT_END  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT_END  = 11'(V_ACTIVE);
  localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [10:0] h_wide;
  logic [10:0] v_wide;
  logic        h_last;
  logic        v_last;
  logic        de_next;
  logic        hs_next;
  logic        vs_next;

  always_comb begin
    h_wide  = {1'b0, h_cnt};
    v_wide  = {1'b0, v_cnt};
    h_last  = (h_wide == H_LAST);
    v_last  = (v_wide == V_LAST);
    de_next = (h_wide < H_ACT_END) && (v_wide < V_ACT_END);
    hs_next = ((h_wide >= HS_START) && (h_wide < HS_END)) ? SYNC_POL : ~SYNC_POL;
    vs_next = ((v_wide >= VS_START) && (v_wide < VS_END)) ? SYNC_POL : ~SYNC_POL;
  end

  // Outputs capture the pre-edge counter value, so every field lines up with x/y.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      x           <= '0;
      y           <= '0;
      de          <= 1'b0;
      hs          <= ~SYNC_POL;
      vs          <= ~SYNC_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_ce) begin
        x           <= h_cnt;
        y           <= v_cnt;
        de          <= de_next;
        hs          <= hs_next;
        vs          <= vs_next;
        line_start  <= (h_cnt == 10'd0);
        frame_start <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
        if (h_last) begin
          h_cnt <= '0;
          v_cnt <= v_last ? 10'd0 : v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default 640x480 instance for the first line, plus a tiny
// 16x8 raster instance (active-high sync) for frame, wrap, enable and reset.
module tb_vga_sync_gen;

  logic       clk;
  logic       rst;
  logic       pix_ce;

  logic       d_hs, d_vs, d_de, d_ls, d_fs;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_de, s_ls, s_fs;
  logic [9:0] s_x, s_y;

  int tests_run = 0;
  int tests_failed = 0;

  vga_sync_gen dut_def (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hs(d_hs), .vs(d_vs), .de(d_de), .x(d_x), .y(d_y),
    .line_start(d_ls), .frame_start(d_fs)
  );

  // Small raster: H 8+2+3+3 = 16, V 4+1+2+1 = 8, hs high at h=10..12, vs high at v=5..6.
  vga_sync_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SYNC_POL(1'b1)
  ) dut_small (
    .clk(clk), .rst(rst), .pix_ce(pix_ce),
    .hs(s_hs), .vs(s_vs), .de(s_de), .x(s_x), .y(s_y),
    .line_start(s_ls), .frame_start(s_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic ce);
    rst    = r;
    pix_ce = ce;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests_run++;
    assert (observed === expected)
    else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    int de_cnt, hs_cnt, hs_first, hs_last, ls_cnt, fs_cnt, vs_cnt, bad;
    int fs_pos [$];
    int h, v, idx;
    logic [9:0] prev_x;

    rst = 1'b1;
    pix_ce = 1'b1;

    // Reset held with pix_ce high.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b1);
      checkOutput("rst_d_hs", d_hs, 1);
      checkOutput("rst_d_vs", d_vs, 1);
      checkOutput("rst_d_de", d_de, 0);
      checkOutput("rst_d_x",  d_x, 0);
      checkOutput("rst_d_y",  d_y, 0);
      checkOutput("rst_d_ls", d_ls, 0);
      checkOutput("rst_d_fs", d_fs, 0);
      checkOutput("rst_s_hs", s_hs, 0);
      checkOutput("rst_s_vs", s_vs, 0);
    end

    // First output cycle after reset release.
    applyStimulus(1'b0, 1'b1);
    checkOutput("first_x",  d_x, 0);
    checkOutput("first_y",  d_y, 0);
    checkOutput("first_de", d_de, 1);
    checkOutput("first_ls", d_ls, 1);
    checkOutput("first_fs", d_fs, 1);
    checkOutput("first_s_fs", s_fs, 1);

    // First default line: 800 cycles.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1; ls_cnt = 0; bad = 0;
    for (int i = 0; i < 800; i++) begin
      if (d_x !== 10'(i) || d_y !== 10'd0) bad++;
      if (d_de) de_cnt++;
      if (d_ls) ls_cnt++;
      if (!d_hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = i;
        hs_last = i;
      end
      if (i < 799) applyStimulus(1'b0, 1'b1);
    end
    checkOutput("line_x_seq",   bad, 0);
    checkOutput("line_de_cnt",  de_cnt, 640);
    checkOutput("line_hs_cnt",  hs_cnt, 96);
    checkOutput("line_hs_first", hs_first, 656);
    checkOutput("line_hs_last", hs_last, 751);
    checkOutput("line_ls_cnt",  ls_cnt, 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("line2_x",  d_x, 0);
    checkOutput("line2_y",  d_y, 1);
    checkOutput("line2_ls", d_ls, 1);
    checkOutput("line2_fs", d_fs, 0);
    checkOutput("line2_de", d_de, 1);
    // Small raster is 800 cycles in: h=0, v=50 mod 8 = 2.
    checkOutput("small_at800_x", s_x, 0);
    checkOutput("small_at800_y", s_y, 2);

    // Advance small raster to x=5, y=3, then a one-cycle mid-frame reset.
    for (int i = 0; i < 21; i++) applyStimulus(1'b0, 1'b1);
    checkOutput("pre_rst_x", s_x, 5);
    checkOutput("pre_rst_y", s_y, 3);
    applyStimulus(1'b1, 1'b1);
    checkOutput("mid_rst_x",  s_x, 0);
    checkOutput("mid_rst_y",  s_y, 0);
    checkOutput("mid_rst_de", s_de, 0);
    checkOutput("mid_rst_hs", s_hs, 0);
    checkOutput("mid_rst_vs", s_vs, 0);
    checkOutput("mid_rst_fs", s_fs, 0);
    checkOutput("mid_rst_d_hs", d_hs, 1);
    checkOutput("mid_rst_d_vs", d_vs, 1);
    applyStimulus(1'b0, 1'b1);

    // Two full small frames against a raster model, plus one cycle of wrap.
    de_cnt = 0; ls_cnt = 0; fs_cnt = 0; vs_cnt = 0; bad = 0;
    for (int i = 0; i <= 256; i++) begin
      h = i % 16;
      v = (i / 16) % 8;
      checkOutput("frm_x",  s_x, h);
      checkOutput("frm_y",  s_y, v);
      checkOutput("frm_de", s_de, (h < 8 && v < 4) ? 1 : 0);
      checkOutput("frm_hs", s_hs, (h >= 10 && h < 13) ? 1 : 0);
      checkOutput("frm_vs", s_vs, (v >= 5 && v < 7) ? 1 : 0);
      checkOutput("frm_ls", s_ls, (h == 0) ? 1 : 0);
      checkOutput("frm_fs", s_fs, (h == 0 && v == 0) ? 1 : 0);
      if (s_x > 10'd15 || s_y > 10'd7) bad++;
      if (i < 256) begin
        if (s_de) de_cnt++;
        if (s_ls) ls_cnt++;
        if (s_vs) vs_cnt++;
      end
      if (s_fs) fs_pos.push_back(i);
      if (i < 256) applyStimulus(1'b0, 1'b1);
    end
    checkOutput("frm_range",  bad, 0);
    checkOutput("frm_de_cnt", de_cnt, 64);
    checkOutput("frm_ls_cnt", ls_cnt, 16);
    checkOutput("frm_vs_cnt", vs_cnt, 64);
    checkOutput("frm_fs_num", fs_pos.size(), 3);
    if (fs_pos.size() == 3) begin
      checkOutput("frm_period1", fs_pos[1] - fs_pos[0], 128);
      checkOutput("frm_period2", fs_pos[2] - fs_pos[1], 128);
    end

    // Clock-enable at half rate: realign with a reset first.
    applyStimulus(1'b1, 1'b1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("ce_first_fs", s_fs, 1);
    ls_cnt = 0; fs_cnt = 0;
    prev_x = s_x;
    for (int c = 1; c <= 256; c++) begin
      applyStimulus(1'b0, (c % 2) == 0);
      idx = (c / 2) % 128;
      h = idx % 16;
      v = idx / 16;
      checkOutput("ce_x",  s_x, h);
      checkOutput("ce_y",  s_y, v);
      checkOutput("ce_de", s_de, (h < 8 && v < 4) ? 1 : 0);
      checkOutput("ce_ls", s_ls, ((c % 2) == 0 && h == 0) ? 1 : 0);
      if (s_ls) ls_cnt++;
      if (s_fs) fs_cnt++;
      if ((c % 2) == 1) checkOutput("ce_hold_x", s_x, prev_x);
      prev_x = s_x;
    end
    checkOutput("ce_fs_at_end", s_fs, 1);
    checkOutput("ce_fs_cnt", fs_cnt, 1);
    checkOutput("ce_ls_cnt", ls_cnt, 8);
    applyStimulus(1'b0, 1'b0);
    checkOutput("ce_strobe_low", s_fs, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
